// File: rtl/imem_loader.sv
// Streams len bytes (0 = 256) into instruction memory from BASE_ADDR while holding the CPU; write appears one cycle after acceptance.
// s_ready depends on state only (LOAD/CHECK); define IMEM_LOADER_CHECKSUM_EN to verify a trailing mod-256 checksum byte.
module imem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_wdata,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  state_t     state;
  logic [8:0] remaining;
  logic [7:0] addr_cnt;
  logic       accept;

  assign s_ready = (state == LOAD) || (state == CHECK);
  assign busy    = (state == LOAD) || (state == CHECK);
  assign done    = (state == DONE);
  assign accept  = s_valid & s_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       err_q;

  assign err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum   <= 8'h00;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sum   <= 8'h00;
        err_q <= 1'b0;
      end else if (state == LOAD && accept) begin
        sum <= sum + s_data;
      end else if (state == CHECK && accept && s_data != sum) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      remaining  <= 9'd0;
      addr_cnt   <= BASE_ADDR;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 8'h00;
      cpu_hold   <= 1'b1;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            remaining <= (len == 8'h00) ? 9'd256 : {1'b0, len};
            addr_cnt  <= BASE_ADDR;
            cpu_hold  <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr_cnt;
            imem_wdata <= s_data;
            addr_cnt   <= addr_cnt + 8'h01;
            remaining  <= remaining - 9'd1;
            if (remaining == 9'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHECK;
`else
              state    <= DONE;
              cpu_hold <= 1'b0;
`endif
            end
          end
        end
        CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          // A bad checksum leaves the CPU held and returns quietly with err set.
          if (accept) begin
            if (s_data == sum) begin
              state    <= DONE;
              cpu_hold <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
`else
          state <= IDLE;
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (BASE_ADDR 00 and FE) share stimulus; a write log is checked against expected address/data lists.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] len = 8'h00;
  logic [7:0] s_data = 8'h00;

  logic       s_ready0, we0, hold0, busy0, done0, err0;
  logic [7:0] addr0, wdata0;
  logic       s_ready1, we1, hold1, busy1, done1, err1;
  logic [7:0] addr1, wdata1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ndone0 = 0;
  int ndone1 = 0;
  logic hold_at_done = 1'b0;
  logic [7:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int wc0[$];
  logic [7:0] dat[256];

  imem_loader u0 (
    .clk(clk), .reset(reset), .start(start), .len(len), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
    .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0)
  );

  imem_loader #(.BASE_ADDR(8'hFE)) u1 (
    .clk(clk), .reset(reset), .start(start), .len(len), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we0) begin
      wa0.push_back(addr0);
      wd0.push_back(wdata0);
      wc0.push_back(cyc);
    end
    if (we1) begin
      wa1.push_back(addr1);
      wd1.push_back(wdata1);
    end
    if (done0) begin
      ndone0 <= ndone0 + 1;
      hold_at_done <= hold0 | busy0;
    end
    if (done1) ndone1 <= ndone1 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    s_data  = b;
    s_valid = 1'b1;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = s_ready0;
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  // Loads dat[0..n-1]; gap_mode 0 = none, 1 = random, 2 = before every odd byte.
  task automatic run_session(input int n, input int gap_mode, input bit mid_start, input bit good);
    int s0 = wa0.size();
    int s1 = wa1.size();
    int d0 = ndone0;
    int d1 = ndone1;
    int sum = 0;
    int nw0, nw1;
    bit fin = 1'b0;
    bit exp_done, exp_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_done = good;
    exp_err  = !good;
`else
    exp_done = 1'b1;
    exp_err  = 1'b0;
`endif
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'($urandom);
    chk("load_busy", 32'(busy0), 32'd1);
    chk("load_hold", 32'(hold0), 32'd1);
    chk("load_err_clr", 32'(err0), 32'd0);
    for (int i = 0; i < n; i++) begin
      if ((gap_mode == 2 && i % 2 == 1) || (gap_mode == 1 && $urandom_range(0, 3) == 0)) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if (mid_start && i == n / 2) begin
        s_valid = 1'b0;
        start   = 1'b1;
        len     = 8'h07;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_byte(dat[i]);
      sum = (sum + int'(dat[i])) % 256;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'(good ? sum : sum + 1));
`endif
    s_valid = 1'b0;
    for (int k = 0; k < 20 && !fin; k++) begin
      @(negedge clk);
      fin = !busy0;
    end
    chk("session_end", 32'(fin), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    nw0 = wa0.size() - s0;
    nw1 = wa1.size() - s1;
    chk("write_count0", 32'(nw0), 32'(n));
    chk("write_count1", 32'(nw1), 32'(n));
    for (int i = 0; i < n && i < nw0 && i < nw1; i++) begin
      chk($sformatf("addr0[%0d]", i), 32'(wa0[s0 + i]), 32'(i % 256));
      chk($sformatf("data0[%0d]", i), 32'(wd0[s0 + i]), 32'(dat[i]));
      chk($sformatf("addr1[%0d]", i), 32'(wa1[s1 + i]), 32'((254 + i) % 256));
      chk($sformatf("data1[%0d]", i), 32'(wd1[s1 + i]), 32'(dat[i]));
    end
    if (gap_mode == 0 && !mid_start) begin
      for (int i = 0; i + 1 < n && i + 1 < nw0; i++)
        chk($sformatf("b2b_gap[%0d]", i), 32'(wc0[s0 + i + 1] - wc0[s0 + i]), 32'd1);
    end
    chk("done_pulses0", 32'(ndone0 - d0), 32'(exp_done));
    chk("done_pulses1", 32'(ndone1 - d1), 32'(exp_done));
    chk("hold_after", 32'(hold0), 32'(!exp_done));
    chk("busy_after", 32'(busy0), 32'd0);
    chk("err_after", 32'(err0), 32'(exp_err));
    if (exp_done) chk("hold_in_done", 32'(hold_at_done), 32'd0);
  endtask

  initial begin
    int s0, d0;
    // Reset behaviour
    #3 reset = 1'b0;
    #1;
    chk("rst_hold", 32'(hold0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_addr0", 32'(addr0), 32'h00);
    chk("rst_addr1", 32'(addr1), 32'hFE);
    chk("rst_ready", 32'(s_ready0 | s_ready1), 32'd0);
    chk("rst_done_err", 32'({done0, err0, done1, err1, we1, busy1}), 32'd0);
    chk("rst_wdata", 32'(wdata0), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_hold", 32'(hold0 & hold1), 32'd1);
    chk("rel_busy", 32'(busy0), 32'd0);
    chk("rel_addr0", 32'(addr0), 32'h00);

    // Three bytes back-to-back
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
    run_session(3, 0, 1'b0, 1'b1);

    // Four bytes with two gaps and an ignored start mid-load
    for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
    run_session(4, 2, 1'b1, 1'b1);

    // len = 0 loads 256 bytes
    for (int i = 0; i < 256; i++) dat[i] = 8'($urandom);
    run_session(256, 1, 1'b0, 1'b1);

    // Random sessions
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) dat[i] = 8'($urandom);
      run_session(n, 1, r[0], 1'b1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    dat[0] = 8'h01; dat[1] = 8'h02;
    run_session(2, 0, 1'b0, 1'b1);
    run_session(2, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) dat[i] = 8'($urandom);
    run_session(6, 1, 1'b0, 1'b1);
`endif

    // Reset after the second of five bytes
    for (int i = 0; i < 5; i++) dat[i] = 8'($urandom);
    s0 = wa0.size();
    d0 = ndone0;
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(dat[0]);
    send_byte(dat[1]);
    s_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_we", 32'(we0), 32'd0);
    chk("abort_hold", 32'(hold0), 32'd1);
    chk("abort_ready", 32'(s_ready0), 32'd0);
    chk("abort_addr", 32'(addr0), 32'h00);
    s_valid = 1'b1;
    s_data  = dat[2];
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("abort_writes", 32'(wa0.size() - s0), 32'd2);
    if (wa0.size() - s0 >= 2) begin
      chk("abort_addr_b0", 32'(wa0[s0]), 32'h00);
      chk("abort_data_b1", 32'(wd0[s0 + 1]), 32'(dat[1]));
    end
    chk("abort_no_done", 32'(ndone0 - d0), 32'd0);
    chk("abort_idle", 32'(busy0 | s_ready0), 32'd0);
    chk("abort_hold_after", 32'(hold0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00, meaning the instruction memory address written by the first byte of a load.
REQ-002 SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load session.
REQ-005 SHALL have port len  input  8  number of instruction bytes to load, sampled with start; 0 means 256.
REQ-006 SHALL have port s_data  input  8  incoming instruction byte.
REQ-007 SHALL have port s_valid  input  1  s_data is valid.
REQ-008 SHALL have port s_ready  output  1  loader accepts s_data this cycle.
REQ-009 SHALL have port imem_we  output  1  instruction memory write strobe.
REQ-010 SHALL have port imem_addr  output  8  instruction memory write address.
REQ-011 SHALL have port imem_wdata  output  8  instruction memory write data.
REQ-012 SHALL have port cpu_hold  output  1  holds the processor (PC and datapath) in reset while high.
REQ-013 SHALL have port busy  output  1  a load session is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-015 SHALL have port err  output  1  sticky checksum error flag.

Function
REQ-016 SHALL implement the states IDLE, LOAD, CHECK and DONE.
REQ-017 SHALL move from IDLE to LOAD on start=1, capturing len into a remaining-count register and setting the address counter to BASE_ADDR.
REQ-018 SHALL clear err on start=1 in IDLE.
REQ-019 SHALL drive s_ready=1 only in LOAD and CHECK; s_ready SHALL be combinational from state only, never from s_valid.
REQ-020 SHALL accept a byte only when s_valid=1 and s_ready=1 at the same rising edge.
REQ-021 On each accepted byte in LOAD, the cycle after acceptance SHALL show imem_we=1, imem_addr=the current address counter and imem_wdata=the accepted byte; imem_we SHALL be 0 in all other cycles.
REQ-022 SHALL increment the address counter modulo 256 after each write, so BASE_ADDR=8'hF0 with len=32 wraps from 8'hFF to 8'h00.
REQ-023 SHALL leave LOAD after the byte that makes the accepted count equal len (256 when len=0), going to CHECK when checksum is compiled in and to DONE otherwise.
REQ-024 SHALL tolerate any number of s_valid=0 gap cycles in LOAD without state change.
REQ-025 SHALL ignore start while not in IDLE.
REQ-026 SHALL stay in DONE for exactly one cycle with done=1, then return to IDLE.
REQ-027 SHALL drive busy=1 in LOAD and CHECK, and 0 otherwise.
REQ-028 SHALL drive cpu_hold=1 from reset until the first DONE, SHALL clear it in the DONE cycle, and SHALL set it again whenever LOAD is entered.

Reset
REQ-029 While reset=0, SHALL asynchronously force state IDLE, s_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, err=0, cpu_hold=1 and clear all counters.
REQ-030 A reset asserted mid-load SHALL abort the session with no further imem_we, leaving already-written bytes in memory.

Configuration
REQ-031 With macro IMEM_LOADER_CHECKSUM_EN defined, SHALL keep a running mod-256 sum of the accepted LOAD bytes and, in CHECK, accept one extra byte that is not written to memory.
REQ-032 With IMEM_LOADER_CHECKSUM_EN defined, if the CHECK byte equals the sum the loader SHALL go to DONE; otherwise it SHALL set err=1, keep cpu_hold=1, raise no done and return to IDLE.
REQ-033 Without IMEM_LOADER_CHECKSUM_EN defined, the CHECK state SHALL be unreachable, err SHALL be tied to 0, and no sum logic SHALL exist.

Verification
REQ-034 SHALL cover: reset=0 then release -> cpu_hold=1, busy=0, imem_we=0, imem_addr=8'h00.
REQ-035 SHALL cover: start with len=3, bytes 8'h11, 8'h22, 8'h33 back-to-back -> writes to 8'h00/8'h01/8'h02 on consecutive cycles, one done pulse, cpu_hold falls.
REQ-036 SHALL cover: len=4 with two s_valid=0 gaps inserted, and start pulsed mid-load -> still exactly 4 writes, start ignored.
REQ-037 SHALL cover: BASE_ADDR=8'hFE, len=4 -> write addresses 8'hFE, 8'hFF, 8'h00, 8'h01; and len=0 -> exactly 256 writes.
REQ-038 SHALL cover, with checksum enabled: bytes 8'h01, 8'h02 then check byte 8'h03 -> done=1, err=0; check byte 8'h04 -> err=1, cpu_hold=1, no done.
REQ-039 SHALL cover: reset=0 after the 2nd of 5 bytes -> immediate IDLE, no further imem_we, cpu_hold=1.
